// File: rtl/sprite_motion_pkg.sv
// Shared types and constants for the sprite motion controller: motion states,
// PS/2 scan codes of the movement keys and their bit positions in the held-key map.
package sprite_motion_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    CROUCH = 3'd2,
    JUMP   = 3'd3,
    FALL   = 3'd4
  } motion_state_e;

  localparam int BREAK_BIT = 9;

  localparam logic [7:0] SC_UP    = 8'h1D;
  localparam logic [7:0] SC_DOWN  = 8'h1B;
  localparam logic [7:0] SC_LEFT  = 8'h1C;
  localparam logic [7:0] SC_RIGHT = 8'h23;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_COUNT = 4;

  // Scan code that drives a given held-map bit.
  function automatic logic [7:0] key_scan(input int idx);
    case (idx)
      KEY_UP:   return SC_UP;
      KEY_DOWN: return SC_DOWN;
      KEY_LEFT: return SC_LEFT;
      default:  return SC_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Frame divider: counts 0..TICK_DIV-1 and raises a registered one-cycle tick
// in the cycle where the count sits at TICK_DIV-1 (the wrapping cycle).
module tick_divider #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_count;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= (r_count == CW'(TICK_DIV - 1)) ? '0 : r_count + 1'b1;
      // Decoding one count early keeps the pulse aligned with the wrap cycle.
      r_tick  <= (r_count == CW'(TICK_DIV - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Player motion controller: tracks held movement keys from PS/2 events and, once per
// frame tick, applies walk/crouch/jump/gravity to produce a clamped sprite position.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int VEL_W        = 8,
  parameter int TICK_DIV     = 1000000,
  parameter int GROUND_LEVEL = 400,
  parameter int X_INIT       = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 600,
  parameter int SPEED        = 6,
  parameter int GRAVITY      = 4,
  parameter int JUMP_SPEED   = 24,
  parameter int MAX_FALL     = 32,
  parameter int MAX_JUMPS    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       keycode,
  input  logic             keycode_valid,
  output logic [POS_W-1:0] X_pos,
  output logic [POS_W-1:0] Y_pos,
  output logic [2:0]       state,
  output logic             facing,
  output logic             on_ground,
  output logic             frame_tick
);

  localparam int SW = POS_W + 2;
  localparam int JW = $clog2(MAX_JUMPS + 1);

  localparam logic signed [SW-1:0]    XMIN_S   = SW'(X_MIN);
  localparam logic signed [SW-1:0]    XMAX_S   = SW'(X_MAX);
  localparam logic signed [SW-1:0]    GROUND_S = SW'(GROUND_LEVEL);
  localparam logic signed [SW-1:0]    SPEED_S  = SW'(SPEED);
  localparam logic signed [VEL_W-1:0] JUMP_V   = VEL_W'(JUMP_SPEED);
  localparam logic signed [VEL_W-1:0] GRAV_V   = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] VY_MIN   = VEL_W'(-MAX_FALL);

  logic [POS_W-1:0]        r_x, r_y;
  logic signed [VEL_W-1:0] r_vy;
  motion_state_e           r_state;
  logic                    r_facing, r_on_ground, r_airborne, r_jump_req;
  logic [KEY_COUNT-1:0]    r_held;
  logic [JW-1:0]           r_jumps_used;

  logic                    w_tick;
  logic [KEY_COUNT-1:0]    w_key_hit;
  logic                    w_is_make, w_up_arm, w_unused_bit;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  for (genvar gi = 0; gi < KEY_COUNT; gi++) begin : g_key
    assign w_key_hit[gi] = keycode_valid && (keycode[7:0] == key_scan(gi));
  end

  assign w_is_make    = !keycode[BREAK_BIT];
  assign w_up_arm     = w_key_hit[KEY_UP] && w_is_make && !r_held[KEY_UP];
  assign w_unused_bit = keycode[8];

  logic                    w_jump_ok, w_air_move, w_air_new, w_facing_new, w_on_ground_new;
  logic signed [VEL_W-1:0] w_vy_move, w_vy_grav, w_vy_new;
  logic [JW-1:0]           w_jumps_move, w_jumps_new;
  logic signed [SW-1:0]    w_dx, w_x_sum, w_y_sum;
  logic [POS_W-1:0]        w_x_new, w_y_new;
  motion_state_e           w_state_new;

  always_comb begin
    w_jump_ok    = r_jump_req && (r_jumps_used < JW'(MAX_JUMPS));
    w_vy_move    = w_jump_ok ? JUMP_V : r_vy;
    w_air_move   = w_jump_ok || r_airborne;
    w_jumps_move = r_jumps_used + JW'(w_jump_ok);

    w_dx = '0;
    if (r_held[KEY_RIGHT] && !r_held[KEY_LEFT]) begin
      w_dx = SPEED_S;
    end else if (r_held[KEY_LEFT] && !r_held[KEY_RIGHT]) begin
      w_dx = -SPEED_S;
    end
    if (!w_air_move && r_held[KEY_DOWN]) begin
      w_dx = '0;
    end

    w_x_sum = $signed({2'b00, r_x}) + w_dx;
    if (w_x_sum < XMIN_S) begin
      w_x_new = POS_W'(X_MIN);
    end else if (w_x_sum > XMAX_S) begin
      w_x_new = POS_W'(X_MAX);
    end else begin
      w_x_new = w_x_sum[POS_W-1:0];
    end

    w_facing_new = r_facing;
    if (w_dx > 0) begin
      w_facing_new = 1'b0;
    end else if (w_dx < 0) begin
      w_facing_new = 1'b1;
    end

    w_y_new     = r_y;
    w_vy_new    = w_vy_move;
    w_air_new   = w_air_move;
    w_jumps_new = w_jumps_move;
    w_y_sum     = $signed({2'b00, r_y}) - SW'(w_vy_move);
    w_vy_grav   = w_vy_move - GRAV_V;
    if (w_air_move) begin
      w_vy_new = (w_vy_grav < VY_MIN) ? VY_MIN : w_vy_grav;
      if (w_y_sum >= GROUND_S) begin
        w_y_new     = POS_W'(GROUND_LEVEL);
        w_vy_new    = '0;
        w_air_new   = 1'b0;
        w_jumps_new = '0;
      end else if (w_y_sum < 0) begin
        w_y_new  = '0;
        w_vy_new = '0;
      end else begin
        w_y_new = w_y_sum[POS_W-1:0];
      end
    end

    // Rising vs. falling is judged on the velocity that moved the sprite this tick,
    // so the apex tick (upward move, velocity now zero) still reads as JUMP.
    if (w_air_new) begin
      w_state_new = (w_vy_move > 0) ? JUMP : FALL;
    end else if (r_held[KEY_DOWN]) begin
      w_state_new = CROUCH;
    end else if (w_dx != 0) begin
      w_state_new = WALK;
    end else begin
      w_state_new = IDLE;
    end
    w_on_ground_new = !w_air_new && (w_y_new == POS_W'(GROUND_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= POS_W'(X_INIT);
      r_y          <= POS_W'(GROUND_LEVEL);
      r_vy         <= '0;
      r_state      <= IDLE;
      r_facing     <= 1'b0;
      r_on_ground  <= 1'b1;
      r_airborne   <= 1'b0;
      r_held       <= '0;
      r_jump_req   <= 1'b0;
      r_jumps_used <= '0;
    end else begin
      r_held <= (r_held & ~w_key_hit) | (w_key_hit & {KEY_COUNT{w_is_make}});
      // A fresh UP press in the tick cycle must survive the clear and fire next tick.
      if (w_up_arm) begin
        r_jump_req <= 1'b1;
      end else if (w_tick) begin
        r_jump_req <= 1'b0;
      end
      if (w_tick) begin
        r_x          <= w_x_new;
        r_y          <= w_y_new;
        r_vy         <= w_vy_new;
        r_state      <= w_state_new;
        r_facing     <= w_facing_new;
        r_on_ground  <= w_on_ground_new;
        r_airborne   <= w_air_new;
        r_jumps_used <= w_jumps_new;
      end
    end
  end

  assign X_pos      = r_x;
  assign Y_pos      = r_y;
  assign state      = r_state;
  assign facing     = r_facing;
  assign on_ground  = r_on_ground;
  assign frame_tick = w_tick;

endmodule
